// File: rtl/vec_itr_ctrl.sv
// vec_itr_ctrl: maskable, vectored priority interrupt controller.
// Rising edges on itr_in set sticky pending bits. Pending bits are ANDed with
// the mask and the global enable, and the lowest-numbered request wins. The
// winner is presented to the control unit as a stable vector, using a
// request/acknowledge handshake. One ISR is tracked until i_ret.
module vec_itr_ctrl #(
  parameter int NUM_ITR    = 8,
  parameter int ADDR_W     = 8,
  parameter int VEC_BASE   = 32'h0000_0090,
  parameter int VEC_STRIDE = 32'd4,
  parameter int ID_W       = $clog2(NUM_ITR)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NUM_ITR-1:0]  itr_in,
  input  logic                itr_en,
  input  logic                itr_clr,
  input  logic                mask_wr,
  input  logic [NUM_ITR-1:0]  mask_in,
  input  logic                i_ack,
  input  logic                i_ret,
  output logic                i_pending,
  output logic [ADDR_W-1:0]   PC_out,
  output logic [ID_W-1:0]     itr_id,
  output logic                busy,
  output logic [NUM_ITR-1:0]  ITR_register,
  output logic [NUM_ITR-1:0]  MASK_register
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_ITR-1:0]   r_pend;
  logic [NUM_ITR-1:0]   r_mask;
  logic [NUM_ITR-1:0]   r_prev;
  logic [ID_W-1:0]      r_id;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_pending;
  logic                 r_busy;

  logic [NUM_ITR-1:0]   w_req;
  logic [NUM_ITR-1:0]   w_edge;
  logic [NUM_ITR-1:0]   w_pend_nxt;
  logic                 w_ack;
  logic                 w_any_req;
  logic                 w_id_req;
  logic [ID_W-1:0]      w_win;

  // Lowest set index of the request vector (channel 0 has the highest priority).
  function automatic logic [ID_W-1:0] f_winner(input logic [NUM_ITR-1:0] req);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_ITR - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = i[ID_W-1:0];
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  // ISR entry address for a channel. The result wraps within ADDR_W bits.
  function automatic logic [ADDR_W-1:0] f_vector(input logic [ID_W-1:0] id);
    int v;
    v = VEC_BASE + int'(id) * VEC_STRIDE;
    return v[ADDR_W-1:0];
  endfunction

  // Request vector, edge detection, and next-state of the pending bits.
  always_comb begin
    w_req      = r_pend & r_mask & {NUM_ITR{itr_en}};
    w_edge     = itr_in & ~r_prev;
    w_ack      = (r_state == ST_REQ) && i_ack;
    w_any_req  = |w_req;
    w_id_req   = w_req[r_id];
    w_win      = f_winner(w_req);
    w_pend_nxt = r_pend;
    for (int i = 0; i < NUM_ITR; i++) begin
      if (itr_clr || (w_ack && (r_id == i[ID_W-1:0]))) begin
        w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = r_pend[i];
      end
      // A fresh edge overrides any clear that happens in the same cycle.
      w_pend_nxt[i] = w_pend_nxt[i] | w_edge[i];
    end
  end

  // Pending bits, mask register, and edge history.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pend <= '0;
      r_mask <= '0;
      r_prev <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_prev <= itr_in;
      if (mask_wr) begin
        r_mask <= mask_in;
      end else begin
        r_mask <= r_mask;
      end
    end
  end

  // Handshake FSM: latch the winner, hold the vector until ack or withdrawal, then track service.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= ST_IDLE;
      r_id      <= '0;
      r_pc      <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state   <= ST_REQ;
            r_id      <= w_win;
            r_pc      <= f_vector(w_win);
            r_pending <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (i_ack) begin
            r_state   <= ST_SERVICE;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end else if (!w_id_req) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_state   <= ST_REQ;
            r_pending <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (i_ret) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_state   <= ST_SERVICE;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign i_pending     = r_pending;
  assign busy          = r_busy;
  assign PC_out        = r_pc;
  assign itr_id        = r_id;
  assign ITR_register  = r_pend;
  assign MASK_register = r_mask;

endmodule
